// File: rtl/naive_bus_arb2.sv
// Two-master, one-slave naive_bus arbiter: round-robin or fixed priority, ownership
// held across slave stalls, one-cycle-late read data steered back to the issuing master.
module naive_bus_arb2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_rd_req,
    output logic        m0_rd_gnt,
    input  logic [31:0] m0_rd_addr,
    output logic [31:0] m0_rd_data,
    input  logic        m0_wr_req,
    output logic        m0_wr_gnt,
    input  logic [31:0] m0_wr_addr,
    input  logic [3:0]  m0_wr_byte_enable,
    input  logic [31:0] m0_wr_data,

    input  logic        m1_rd_req,
    output logic        m1_rd_gnt,
    input  logic [31:0] m1_rd_addr,
    output logic [31:0] m1_rd_data,
    input  logic        m1_wr_req,
    output logic        m1_wr_gnt,
    input  logic [31:0] m1_wr_addr,
    input  logic [3:0]  m1_wr_byte_enable,
    input  logic [31:0] m1_wr_data,

    output logic        s_rd_req,
    input  logic        s_rd_gnt,
    output logic [31:0] s_rd_addr,
    input  logic [31:0] s_rd_data,
    output logic        s_wr_req,
    input  logic        s_wr_gnt,
    output logic [31:0] s_wr_addr,
    output logic [3:0]  s_wr_byte_enable,
    output logic [31:0] s_wr_data
);

    logic req0;
    logic req1;
    logic ptr;
    logic hold_vld;
    logic hold_id;
    logic rd_vld;
    logic rd_id;
    logic own_vld;
    logic owner;
    logic hold_hit;
    logic rd_fire;
    logic complete;

    assign req0 = m0_rd_req | m0_wr_req;
    assign req1 = m1_rd_req | m1_wr_req;

    // A held master that dropped its request releases the hold in the same cycle.
    assign hold_hit = hold_vld & (hold_id ? req1 : req0);

    always_comb begin
        own_vld = 1'b0;
        owner   = 1'b0;
        if (hold_hit) begin
            own_vld = 1'b1;
            owner   = hold_id;
        end else if (req0 && !req1) begin
            own_vld = 1'b1;
            owner   = 1'b0;
        end else if (req1 && !req0) begin
            own_vld = 1'b1;
            owner   = 1'b1;
        end else if (req0 && req1) begin
            own_vld = 1'b1;
            owner   = (PRIO_MODE == 0) ? ptr : 1'b0;
        end
    end

    always_comb begin
        s_rd_req         = 1'b0;
        s_rd_addr        = 32'h0;
        s_wr_req         = 1'b0;
        s_wr_addr        = 32'h0;
        s_wr_byte_enable = 4'h0;
        s_wr_data        = 32'h0;
        if (own_vld) begin
            if (owner) begin
                s_rd_req         = m1_rd_req;
                s_rd_addr        = m1_rd_addr;
                s_wr_req         = m1_wr_req;
                s_wr_addr        = m1_wr_addr;
                s_wr_byte_enable = m1_wr_byte_enable;
                s_wr_data        = m1_wr_data;
            end else begin
                s_rd_req         = m0_rd_req;
                s_rd_addr        = m0_rd_addr;
                s_wr_req         = m0_wr_req;
                s_wr_addr        = m0_wr_addr;
                s_wr_byte_enable = m0_wr_byte_enable;
                s_wr_data        = m0_wr_data;
            end
        end
    end

    assign m0_rd_gnt = own_vld & ~owner & s_rd_gnt;
    assign m0_wr_gnt = own_vld & ~owner & s_wr_gnt;
    assign m1_rd_gnt = own_vld &  owner & s_rd_gnt;
    assign m1_wr_gnt = own_vld &  owner & s_wr_gnt;

    assign rd_fire  = own_vld & s_rd_req & s_rd_gnt;
    assign complete = rd_fire | (own_vld & s_wr_req & s_wr_gnt);

    // Arbitration state: fairness pointer and stall ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            hold_vld <= 1'b0;
            hold_id  <= 1'b0;
        end else if (complete) begin
            if (PRIO_MODE == 0) begin
                ptr <= ~owner;
            end
            hold_vld <= 1'b0;
        end else if (own_vld) begin
            hold_vld <= 1'b1;
            hold_id  <= owner;
        end else begin
            hold_vld <= 1'b0;
        end
    end

    // Read-return tag: remembers who was granted the read whose data arrives next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_id  <= 1'b0;
        end else begin
            rd_vld <= rd_fire;
            if (rd_fire) begin
                rd_id <= owner;
            end
        end
    end

    assign m0_rd_data = (rd_vld && !rd_id) ? s_rd_data : 32'h0;
    assign m1_rd_data = (rd_vld &&  rd_id) ? s_rd_data : 32'h0;

endmodule

// File: tb/tb_naive_bus_arb2.sv
// Scoreboard bench for naive_bus_arb2: stimulus pushes expected slave-side transfers and
// read returns; a negedge monitor pops and compares them as the DUT presents them.
module tb_naive_bus_arb2;

    typedef struct packed {
        logic [1:0]  grd;    // {m1, m0} read grants
        logic [1:0]  gwr;    // {m1, m0} write grants
        logic        srd;
        logic        swr;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        m0_rd_req = 0, m0_wr_req = 0, m1_rd_req = 0, m1_wr_req = 0;
    logic [31:0] m0_rd_addr = 0, m0_wr_addr = 0, m0_wr_data = 0;
    logic [31:0] m1_rd_addr = 0, m1_wr_addr = 0, m1_wr_data = 0;
    logic [3:0]  m0_wr_be = 0, m1_wr_be = 0;
    logic        m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt;
    logic [31:0] m0_rd_data, m1_rd_data;

    logic        s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
    logic [31:0] s_rd_addr, s_wr_addr, s_wr_data;
    logic [31:0] s_rd_data = 32'hdead_beef;
    logic [3:0]  s_wr_be;
    logic        rd_en = 1'b1, wr_en = 1'b1;

    // Fixed-priority instance
    logic        fp_on = 1'b0;
    logic        fp_m0_rd_gnt, fp_m0_wr_gnt, fp_m1_rd_gnt, fp_m1_wr_gnt;
    logic [31:0] fp_m0_rd_data, fp_m1_rd_data;
    logic        fp_s_rd_req, fp_s_wr_req;
    logic [31:0] fp_s_rd_addr, fp_s_wr_addr, fp_s_wr_data;
    logic [3:0]  fp_s_wr_be;

    int errors = 0;
    int checks = 0;
    bus_t        gq[$];
    logic [63:0] dq[$];
    logic        prev_rdg = 1'b0;

    always #5 clk = ~clk;

    assign s_rd_gnt = s_rd_req & rd_en;
    assign s_wr_gnt = s_wr_req & wr_en;

    // ROM slave: data = address, one cycle after the read grant.
    always @(posedge clk) begin
        if (s_rd_req && s_rd_gnt) s_rd_data <= s_rd_addr;
        else                      s_rd_data <= 32'hdead_beef;
    end

    naive_bus_arb2 #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_req(m0_rd_req), .m0_rd_gnt(m0_rd_gnt), .m0_rd_addr(m0_rd_addr), .m0_rd_data(m0_rd_data),
        .m0_wr_req(m0_wr_req), .m0_wr_gnt(m0_wr_gnt), .m0_wr_addr(m0_wr_addr),
        .m0_wr_byte_enable(m0_wr_be), .m0_wr_data(m0_wr_data),
        .m1_rd_req(m1_rd_req), .m1_rd_gnt(m1_rd_gnt), .m1_rd_addr(m1_rd_addr), .m1_rd_data(m1_rd_data),
        .m1_wr_req(m1_wr_req), .m1_wr_gnt(m1_wr_gnt), .m1_wr_addr(m1_wr_addr),
        .m1_wr_byte_enable(m1_wr_be), .m1_wr_data(m1_wr_data),
        .s_rd_req(s_rd_req), .s_rd_gnt(s_rd_gnt), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
        .s_wr_req(s_wr_req), .s_wr_gnt(s_wr_gnt), .s_wr_addr(s_wr_addr),
        .s_wr_byte_enable(s_wr_be), .s_wr_data(s_wr_data)
    );

    naive_bus_arb2 #(.PRIO_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_req(fp_on), .m0_rd_gnt(fp_m0_rd_gnt), .m0_rd_addr(32'h0), .m0_rd_data(fp_m0_rd_data),
        .m0_wr_req(1'b0), .m0_wr_gnt(fp_m0_wr_gnt), .m0_wr_addr(32'h0),
        .m0_wr_byte_enable(4'h0), .m0_wr_data(32'h0),
        .m1_rd_req(fp_on), .m1_rd_gnt(fp_m1_rd_gnt), .m1_rd_addr(32'h4), .m1_rd_data(fp_m1_rd_data),
        .m1_wr_req(1'b0), .m1_wr_gnt(fp_m1_wr_gnt), .m1_wr_addr(32'h0),
        .m1_wr_byte_enable(4'h0), .m1_wr_data(32'h0),
        .s_rd_req(fp_s_rd_req), .s_rd_gnt(fp_s_rd_req), .s_rd_addr(fp_s_rd_addr), .s_rd_data(32'h0),
        .s_wr_req(fp_s_wr_req), .s_wr_gnt(fp_s_wr_req), .s_wr_addr(fp_s_wr_addr),
        .s_wr_byte_enable(fp_s_wr_be), .s_wr_data(fp_s_wr_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply the current inputs for one cycle; exp_owner is the hand-derived winner (-1: none).
    task automatic step(input int exp_owner, input bit killed = 1'b0);
        bus_t e;
        e = '0;
        if (exp_owner == 0) begin
            e.srd = m0_rd_req; e.swr = m0_wr_req; e.raddr = m0_rd_addr;
            e.waddr = m0_wr_addr; e.be = m0_wr_be; e.wdata = m0_wr_data;
        end else if (exp_owner == 1) begin
            e.srd = m1_rd_req; e.swr = m1_wr_req; e.raddr = m1_rd_addr;
            e.waddr = m1_wr_addr; e.be = m1_wr_be; e.wdata = m1_wr_data;
        end
        if (exp_owner >= 0) begin
            e.grd[exp_owner] = e.srd & rd_en;
            e.gwr[exp_owner] = e.swr & wr_en;
            gq.push_back(e);
            if (e.srd && rd_en) begin
                if (killed)              dq.push_back(64'h0);
                else if (exp_owner == 0) dq.push_back({32'h0, e.raddr});
                else                     dq.push_back({e.raddr, 32'h0});
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bus_t a, e;
        a = '{grd: {m1_rd_gnt, m0_rd_gnt}, gwr: {m1_wr_gnt, m0_wr_gnt}, srd: s_rd_req,
              swr: s_wr_req, raddr: s_rd_addr, waddr: s_wr_addr, be: s_wr_be, wdata: s_wr_data};
        if (s_rd_req || s_wr_req || a.grd != 0 || a.gwr != 0) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_transfer: got %h expected none", a);
            end else begin
                e = gq.pop_front();
                checks--;
                chk("transfer", {26'h0, a.grd, a.gwr, a.srd, a.swr, a.raddr[31:0]} ,
                                {26'h0, e.grd, e.gwr, e.srd, e.swr, e.raddr[31:0]});
                chk("write_fields", {a.waddr, a.wdata}, {e.waddr, e.wdata});
                chk("write_be", {60'h0, a.be}, {60'h0, e.be});
            end
        end
        if (prev_rdg) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_return: got %h expected none", {m1_rd_data, m0_rd_data});
            end else begin
                checks--;
                chk("rd_return", {m1_rd_data, m0_rd_data}, dq.pop_front());
            end
        end else begin
            chk("rd_data_idle", {m1_rd_data, m0_rd_data}, 64'h0);
        end
        prev_rdg = m0_rd_gnt | m1_rd_gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        repeat (2) @(negedge clk);
        chk("rst_s_out", {s_rd_req, s_wr_req, s_rd_addr, s_wr_be}, 64'h0);
        chk("rst_grants", {m0_rd_gnt, m0_wr_gnt, m1_rd_gnt, m1_wr_gnt, u_rr.rd_vld, u_rr.ptr, u_rr.hold_vld}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(-1);

        // Alternating reads, ROM returns data = addr
        m0_rd_req = 1; m0_rd_addr = 32'h0;
        m1_rd_req = 1; m1_rd_addr = 32'h4;
        step(0); step(1); step(0);

        // Stall while m0 owns and m1 requests; ptr favours m1 but the hold wins
        m1_rd_req = 0; m0_rd_addr = 32'h10; rd_en = 0;
        step(0);
        m1_rd_req = 1;
        step(0); step(0);
        rd_en = 1;
        step(0);
        m0_rd_req = 0;
        step(1);
        m1_rd_req = 0;
        step(-1);

        // m0 write vs m1 read
        m0_wr_req = 1; m0_wr_addr = 32'h30000; m0_wr_be = 4'b0001; m0_wr_data = 32'h68;
        m1_rd_req = 1; m1_rd_addr = 32'h8;
        step(0);
        m0_wr_req = 0; m0_wr_addr = 0; m0_wr_be = 0; m0_wr_data = 0;
        step(1);
        m1_rd_req = 0;
        step(-1);

        // Reset pulse right after an m1 read grant
        m1_rd_req = 1; m1_rd_addr = 32'hC;
        step(1, 1'b1);
        m1_rd_req = 0;
        rst_n = 1'b0;
        step(-1);
        rst_n = 1'b1;
        chk("rst_rd_vld", {63'h0, u_rr.rd_vld}, 64'h0);
        chk("rst_m1_rdata", {32'h0, m1_rd_data}, 64'h0);
        step(-1);

        // First contention after reset goes to m0
        m0_rd_req = 1; m0_rd_addr = 32'h20;
        m1_rd_req = 1; m1_rd_addr = 32'h24;
        step(0);
        m0_rd_req = 0; m1_rd_req = 0;
        step(-1);
        step(-1);
        chk("grant_q_empty", 64'(gq.size()), 64'h0);
        chk("data_q_empty", 64'(dq.size()), 64'h0);

        // Fixed priority: m0 takes every grant
        fp_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("fp_grants", {62'h0, fp_m1_rd_gnt, fp_m0_rd_gnt}, 64'h1);
            @(posedge clk); #1;
        end
        fp_on = 1'b0;
        step(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/naive_bus_arb2.md
# naive_bus_arb2

Two-master, one-slave arbiter for the naive_bus fabric. It lets the CPU instruction port (m0) and a second master (m1, e.g. the UART debug loader or the CPU data port) share one slave, such as the instruction ROM or a RAM. It forwards one master's request per cycle, holds ownership across slave stalls, and routes the one-cycle-late read data back to the master that issued the read.

## Interface
- PRIO_MODE, default 0: arbitration policy.
  - 0: round-robin.
  - 1: fixed priority, m0 wins.
- Every naive_bus port below carries these members:
  - rd_req
  - rd_gnt
  - rd_addr[31:0]
  - rd_data[31:0]
  - wr_req
  - wr_gnt
  - wr_addr[31:0]
  - wr_byte_enable[3:0]
  - wr_data[31:0]
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0  naive_bus.slave  —  master 0 port.
- m1  naive_bus.slave  —  master 1 port.
- s  naive_bus.master  —  shared slave port.

## Operation
- Request of master i: req_i = mi.rd_req | mi.wr_req.
- State registers:
  - ptr (1 bit): preferred master.
  - hold_vld, hold_id: ownership held during a slave stall.
  - rd_vld, rd_id: owner of the read data returned this cycle.
- Owner selection (combinational, every cycle):
  - If hold_vld and req_{hold_id}: owner = hold_id.
  - Else if only one master requests: owner = that master.
  - Else if both request: owner = ptr in round-robin mode; owner = 0 in fixed mode.
  - Else: no owner.
- Forwarding to the slave:
  - With an owner, s.rd_req, rd_addr, wr_req, wr_addr, wr_byte_enable and wr_data are copied from that owner.
  - With no owner, all s outputs are 0.
- Grants back to masters:
  - m_owner.rd_gnt = s.rd_gnt and m_owner.wr_gnt = s.wr_gnt.
  - The non-owner's grants are 0.
- Completion: a cycle where the owner has (s.rd_req & s.rd_gnt) | (s.wr_req & s.wr_gnt).
  - ptr <= ~owner in round-robin mode; ptr is unused in fixed mode.
  - hold_vld <= 0.
- Stall: an owner is selected but the transaction does not complete.
  - hold_vld <= 1, hold_id <= owner.
  - The other master cannot take the bus until this transaction completes.
- Hold release: if the held master drops its request without a grant, hold_vld <= 0 and normal selection resumes in the same cycle.
- Read return:
  - On a cycle with s.rd_req & s.rd_gnt: rd_vld <= 1, rd_id <= owner. Otherwise rd_vld <= 0.
  - When rd_vld = 1: m_{rd_id}.rd_data = s.rd_data and the other master's rd_data = 0.
  - When rd_vld = 0: both masters' rd_data = 0.
- Simultaneous read and write by the owner: both are forwarded together. The arbiter does not split them; the slave defines the ordering.

## Timing
- Reset values:
  - ptr = 0, hold_vld = 0, rd_vld = 0.
  - All s outputs 0; all master grants 0; all master rd_data 0 (while no requests).
- Request to grant: 0 cycles, combinational, when the slave grants combinationally.
- Read data reaches the owning master exactly 1 cycle after its rd_gnt.
  - It stays correctly routed even when the other master owns the bus in that cycle (back-to-back reads from alternating masters).
- Back-to-back completions with both masters requesting alternate 0,1,0,1 in round-robin mode. Neither master is ever granted twice in a row while the other waits.
- Reset asserted mid-transaction: all state clears immediately. Any pending read return is dropped and nothing is delivered after reset releases.
- No combinational path from s.rd_data to any s output.

## Test plan
- Reset then idle:
  - All s outputs = 0 and all master grants = 0.
  - After release, the first contention is won by m0 (ptr = 0).
- Both masters issue reads every cycle (m0 addr 0x0, m1 addr 0x4) to a ROM returning data = addr:
  - Grants alternate m0, m1, m0.
  - m0.rd_data = 0x0 and m1.rd_data = 0x4 on the cycle after each respective grant; the other master's rd_data = 0.
- Slave holds rd_gnt = 0 for 3 cycles while m0 owns and m1 requests:
  - s.rd_addr stays at m0's address for all 4 cycles.
  - m1 is granted on the cycle after m0 completes.
- m0 writes 0x68 to 0x30000 with byte_enable 0001 while m1 reads 0x8:
  - Exactly one transaction is forwarded per cycle.
  - The write reaches s with the correct byte_enable, and m1 receives 0 rd_data on the write cycle.
- PRIO_MODE = 1, both requesting continuously for 10 cycles: m0 receives all 10 grants and m1 none.
- Reset pulse the cycle after an m1 read grant: m1.rd_data = 0 on the following cycle and rd_vld = 0.
